// File: rtl/cache_pkg.sv
// Shared cache types, widths and address-field helpers for the data and instruction caches.
package cache_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned BLOCK_W     = 128;
  localparam int unsigned WORD_OFF_W  = 2;
  localparam int unsigned BLOCK_OFF_W = 4;
  localparam int unsigned MEM_ADDR_W  = ADDR_W - BLOCK_OFF_W;

  typedef enum logic [1:0] {
    IDLE,
    WRITE_BACK,
    ALLOCATE,
    UPDATE
  } state_e;

  typedef struct packed {
    logic                  rd;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [BLOCK_W-1:0]    data;
  } mem_req_t;

  function automatic logic [MEM_ADDR_W-1:0] addr_block(input logic [ADDR_W-1:0] a);
    return a[ADDR_W-1:BLOCK_OFF_W];
  endfunction

  function automatic logic [WORD_OFF_W-1:0] addr_word_off(input logic [ADDR_W-1:0] a);
    return a[BLOCK_OFF_W-1:BLOCK_OFF_W-WORD_OFF_W];
  endfunction

  // Index and tag are returned zero-extended; callers cast to their own widths.
  function automatic logic [ADDR_W-1:0] addr_index(input logic [ADDR_W-1:0] a,
                                                   input int unsigned index_bits);
    return (a >> BLOCK_OFF_W) & ((ADDR_W'(1) << index_bits) - ADDR_W'(1));
  endfunction

  function automatic logic [ADDR_W-1:0] addr_tag(input logic [ADDR_W-1:0] a,
                                                 input int unsigned index_bits);
    return a >> (BLOCK_OFF_W + index_bits);
  endfunction

endpackage

// File: rtl/dcache_ctrl_fsm.sv
// Miss-handling controller: state register, next-state logic and registered memory requests.
module dcache_ctrl_fsm
  import cache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_i,
  input  logic                  hit_i,
  input  logic                  dirty_i,
  input  logic                  mem_busywait_i,
  input  logic [MEM_ADDR_W-1:0] req_blk_i,
  input  logic [MEM_ADDR_W-1:0] victim_blk_i,
  input  logic [BLOCK_W-1:0]    victim_data_i,
  output state_e                state_o,
  output mem_req_t              mem_req_o
);

  state_e   state_q, state_d;
  mem_req_t mem_req_q, mem_req_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (req_i && !hit_i) state_d = dirty_i ? WRITE_BACK : ALLOCATE;
      WRITE_BACK: if (!mem_busywait_i) state_d = ALLOCATE;
      ALLOCATE:   if (!mem_busywait_i) state_d = UPDATE;
      UPDATE:     state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Requests follow the next state so they rise the cycle after the miss and drop after completion.
  always_comb begin
    mem_req_d = '0;
    unique case (state_d)
      WRITE_BACK: begin
        mem_req_d.wr   = 1'b1;
        mem_req_d.addr = victim_blk_i;
        mem_req_d.data = victim_data_i;
      end
      ALLOCATE: begin
        mem_req_d.rd   = 1'b1;
        mem_req_d.addr = req_blk_i;
      end
      default: mem_req_d = '0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      mem_req_q <= '0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign state_o   = state_q;
  assign mem_req_o = mem_req_q;

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with 128-bit blocks.
module data_cache
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 3,
  parameter int unsigned TAG_BITS   = 32 - INDEX_BITS - 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_W-1:0]     address,
  input  logic [WORD_W-1:0]     writedata,
  output logic [WORD_W-1:0]     readdata,
  output logic                  busywait,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [BLOCK_W-1:0]    mem_writedata,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
);

  localparam int unsigned SETS = 1 << INDEX_BITS;

  logic [SETS-1:0]     valid_q;
  logic [SETS-1:0]     dirty_q;
  logic [TAG_BITS-1:0] tag_q  [SETS];
  logic [BLOCK_W-1:0]  data_q [SETS];
  logic [BLOCK_W-1:0]  fill_q;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tag;
  logic [WORD_OFF_W-1:0] off;
  logic [BLOCK_W-1:0]    sel_blk;
  logic                  hit;
  logic                  req;
  logic                  write_hit;
  state_e                state;
  mem_req_t              mem_req;

  assign idx       = INDEX_BITS'(addr_index(address, INDEX_BITS));
  assign tag       = TAG_BITS'(addr_tag(address, INDEX_BITS));
  assign off       = addr_word_off(address);
  assign sel_blk   = data_q[idx];
  assign hit       = valid_q[idx] && (tag_q[idx] == tag);
  assign req       = read || write;
  assign write_hit = write && hit && (state == IDLE);

  assign readdata = valid_q[idx] ? sel_blk[{off, 5'b0} +: WORD_W] : '0;
  assign busywait = req && !((state == IDLE) && hit);

  dcache_ctrl_fsm u_ctrl (
    .clk_i          (CLK),
    .rst_i          (RESET),
    .req_i          (req),
    .hit_i          (hit),
    .dirty_i        (dirty_q[idx]),
    .mem_busywait_i (mem_busywait),
    .req_blk_i      (addr_block(address)),
    .victim_blk_i   ({tag_q[idx], idx}),
    .victim_data_i  (sel_blk),
    .state_o        (state),
    .mem_req_o      (mem_req)
  );

  assign mem_read      = mem_req.rd;
  assign mem_write     = mem_req.wr;
  assign mem_address   = mem_req.addr;
  assign mem_writedata = mem_req.data;

  // Line status bits are the only storage that needs reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (state == UPDATE) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (write_hit) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if ((state == ALLOCATE) && !mem_busywait) begin
      fill_q <= mem_readdata;
    end
    if (state == UPDATE) begin
      data_q[idx] <= fill_q;
      tag_q[idx]  <= tag;
    end else if (write_hit) begin
      data_q[idx][{off, 5'b0} +: WORD_W] <= writedata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache against a flat word-memory reference and a latency-4 block memory.
module tb_data_cache;

  localparam int LAT = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic         read = 1'b0;
  logic         write = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  writedata = '0;
  logic [31:0]  readdata;
  logic         busywait;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_address;
  logic [127:0] mem_writedata;
  logic [127:0] mem_readdata;
  logic         mem_busywait;

  int checks = 0;
  int errors = 0;

  logic [127:0] backing [1024];
  logic [31:0]  ref_map [logic [31:0]];
  int           mcnt = 0;

  int           stall;
  logic         saw_rd, saw_wr;
  logic [27:0]  rd_addr, wr_addr;
  logic [127:0] wr_blk;
  logic [31:0]  rdata;

  data_cache dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .read          (read),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .readdata      (readdata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait)
  );

  always #5 CLK = ~CLK;

  // Block memory: a held request completes on its LAT-th cycle.
  assign mem_busywait = (mem_read || mem_write) && (mcnt != LAT - 1);
  assign mem_readdata = backing[mem_address[9:0]];

  always @(posedge CLK) begin
    if ((mem_read || mem_write) && !mem_busywait) begin
      if (mem_write) backing[mem_address[9:0]] = mem_writedata;
      mcnt <= 0;
    end else if (mem_read || mem_write) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
    end
  end

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [127:0] b;
    if (ref_map.exists(a)) return ref_map[a];
    b = backing[a[13:4]];
    return b[int'(a[3:2]) * 32 +: 32];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the coherent word-memory view.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (!(read || write)) chk("idle_busywait", 32'(busywait), 32'd0);
      if (read && !write && !busywait) chk("load_data", readdata, ref_word(address));
      if (mem_read || mem_write) begin
        chk("mem_req_stalls", 32'(busywait), 32'd1);
        chk("mem_req_exclusive", 32'(mem_read && mem_write), 32'd0);
        chk("mem_req_index", 32'(mem_address[2:0]), 32'(address[6:4]));
      end
      if (mem_read) chk("fetch_addr", 32'(mem_address), 32'(address[31:4]));
      if (mem_write) begin
        for (int k = 0; k < 4; k++)
          chk("evict_word", mem_writedata[k*32 +: 32], ref_word({mem_address, 2'(k), 2'b00}));
      end
      if (write && !busywait) ref_map[address] = writedata;
    end
  end

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d);
    logic done;
    read = rd; write = wr; address = a; writedata = d;
    stall = 0; saw_rd = 1'b0; saw_wr = 1'b0; done = 1'b0;
    rd_addr = '0; wr_addr = '0; wr_blk = '0;
    for (int n = 0; n < 64; n++) begin
      @(negedge CLK);
      if (mem_read)  begin saw_rd = 1'b1; rd_addr = mem_address; end
      if (mem_write) begin saw_wr = 1'b1; wr_addr = mem_address; wr_blk = mem_writedata; end
      if (!busywait) begin done = 1'b1; break; end
      stall++;
    end
    if (!done) chk("access_timeout", 32'(stall), 32'd0);
    rdata = readdata;
    @(posedge CLK); #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    for (int b = 0; b < 1024; b++)
      for (int k = 0; k < 4; k++)
        backing[b][k*32 +: 32] = {18'd0, 10'(b), 2'(k), 2'b00} ^ 32'hA5A5_0000;

    // Reset state
    @(negedge CLK);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_busywait", 32'(busywait), 32'd0);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_mem_address", 32'(mem_address), 32'd0);
    chk("rst_mem_writedata", 32'(|mem_writedata), 32'd0);
    @(posedge CLK); #1;
    RESET = 1'b0;

    // Clean read miss then hits
    do_access(1'b1, 1'b0, 32'h10, '0);
    chk("miss_stall", 32'(stall), 32'd6);
    chk("miss_fetch", 32'(saw_rd), 32'd1);
    chk("miss_fetch_addr", 32'(rd_addr), 32'h1);
    chk("miss_no_wb", 32'(saw_wr), 32'd0);
    chk("miss_data", rdata, 32'hA5A5_0010);
    do_access(1'b1, 1'b0, 32'h14, '0);
    chk("hit_stall", 32'(stall), 32'd0);
    chk("hit_data", rdata, 32'hA5A5_0014);

    // Store hit, readback next cycle
    do_access(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF);
    chk("store_hit_stall", 32'(stall), 32'd0);
    do_access(1'b1, 1'b0, 32'h14, '0);
    chk("store_readback", rdata, 32'hDEAD_BEEF);

    // Dirty conflict miss
    do_access(1'b1, 1'b0, 32'h94, '0);
    chk("dirty_stall", 32'(stall), 32'd10);
    chk("wb_addr", 32'(wr_addr), 32'h1);
    chk("wb_word1", wr_blk[63:32], 32'hDEAD_BEEF);
    chk("alloc_addr", 32'(rd_addr), 32'h9);
    chk("dirty_data", rdata, 32'hA5A5_0094);

    // Write miss to clean set
    do_access(1'b0, 1'b1, 32'h200, 32'h1234_5678);
    chk("wmiss_stall", 32'(stall), 32'd6);
    chk("wmiss_no_wb", 32'(saw_wr), 32'd0);
    chk("wmiss_alloc_addr", 32'(rd_addr), 32'h20);
    do_access(1'b1, 1'b0, 32'h200, '0);
    chk("wmiss_readback", rdata, 32'h1234_5678);
    do_access(1'b1, 1'b0, 32'h600, '0);
    chk("wmiss_dirty_wb", 32'(saw_wr), 32'd1);
    chk("wmiss_wb_addr", 32'(wr_addr), 32'h20);
    chk("wmiss_wb_word0", wr_blk[31:0], 32'h1234_5678);
    chk("evict2_data", rdata, 32'hA5A5_0600);

    // Reset during ALLOCATE
    read = 1'b1; address = 32'h310;
    for (int n = 0; n < 10 && !mem_read; n++) @(negedge CLK);
    chk("pre_rst_fetch", 32'(mem_read), 32'd1);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mid_mem_write", 32'(mem_write), 32'd0);
    read = 1'b0; address = 32'h10;
    @(posedge CLK); #1;
    RESET = 1'b0;
    ref_map.delete();
    @(negedge CLK);
    chk("rst_mid_invalid", readdata, 32'd0);
    @(posedge CLK); #1;
    do_access(1'b1, 1'b0, 32'h14, '0);
    chk("post_rst_miss", 32'(stall), 32'd6);
    chk("post_rst_data", rdata, 32'hDEAD_BEEF);
    do_access(1'b1, 1'b0, 32'h200, '0);
    chk("post_rst_miss2", 32'(stall), 32'd6);
    chk("post_rst_data2", rdata, 32'h1234_5678);

    // Back-to-back hits on alternating sets
    for (int i = 0; i < 16; i++) begin
      a = ((i % 2) == 0 ? 32'h10 : 32'h200) + 32'(((i / 2) % 4) * 4);
      do_access(((i % 4) != 3), ((i % 4) == 3), a, 32'hC0DE_0000 + 32'(i));
      chk("b2b_stall", 32'(stall), 32'd0);
      chk("b2b_no_mem", 32'(saw_rd || saw_wr), 32'd0);
    end
    do_access(1'b1, 1'b0, 32'h20C, '0);
    chk("b2b_last_store", rdata, 32'hC0DE_000F);

    // Read and write together: the write wins
    do_access(1'b1, 1'b1, 32'h18, 32'h55AA_55AA);
    chk("rw_stall", 32'(stall), 32'd0);
    do_access(1'b1, 1'b0, 32'h18, '0);
    chk("rw_write_priority", rdata, 32'h55AA_55AA);

    repeat (2) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_cache.md
# data_cache

Direct-mapped, write-back, write-allocate data cache sitting directly downstream of the CPU's memory-access stage. It serves the word-aligned loads and stores issued from pipeline register 3 and returns `busywait` to stall the pipeline on a miss. On a miss it fetches or evicts 128-bit blocks from the data memory.

## Interface
Parameters:
- `INDEX_BITS`, 3: set index width (8 sets); block is fixed at 4 words / 128 bits.
- `TAG_BITS`, 25: `32 - INDEX_BITS - 4`.

Ports:
- `CLK`  in  1  sole clock, rising edge.
- `RESET`  in  1  asynchronous, active-high reset.
- `read`  in  1  CPU load request (the `cache_memRead` signal).
- `write`  in  1  CPU store request (the `cache_memWrite` signal).
- `address`  in  32  CPU byte address. `[3:2]` word offset, `[3+INDEX_BITS:4]` index, `[31:4+INDEX_BITS]` tag.
- `writedata`  in  32  store word, already refined by the data-refining stage.
- `readdata`  out  32  load word, combinational from the selected line.
- `busywait`  out  1  pipeline stall request.
- `mem_read`  out  1  block fetch request to data memory.
- `mem_write`  out  1  block write-back request to data memory.
- `mem_address`  out  28  block address, equal to byte address `[31:4]`.
- `mem_writedata`  out  128  evicted block, with word 0 in `[31:0]`.
- `mem_readdata`  in  128  fetched block.
- `mem_busywait`  in  1  memory busy; the transfer is complete on the first cycle it is low while a request is held.

## Operation
- Per set: `valid`, `dirty`, tag, and a 128-bit block.
- `hit` = `valid[index]` && `tag[index] == address tag`.
- States:
  - **IDLE**
    - Request with hit:
      - Read: `readdata` = selected word, `busywait` = 0.
      - Write: the word is written at the next rising edge and `dirty` is set.
    - Request with miss: next state is WRITE_BACK if `dirty[index]`, else ALLOCATE.
  - **WRITE_BACK**
    - Drives `mem_write` = 1, `mem_address` = {stored tag, index}, `mem_writedata` = block.
    - When `mem_busywait` = 0, next state is ALLOCATE.
  - **ALLOCATE**
    - Drives `mem_read` = 1, `mem_address` = {request tag, index}.
    - When `mem_busywait` = 0, `mem_readdata` is captured and next state is UPDATE.
  - **UPDATE**
    - Writes the block, the tag, `valid` = 1 and `dirty` = 0.
    - Next state is IDLE, where the request retries as a hit.
- `busywait` = (`read` | `write`) && !(state == IDLE && hit). It is 1 throughout WRITE_BACK, ALLOCATE and UPDATE.
- `read` and `write` asserted together is illegal; write takes priority.
- Requests that change while `busywait` = 1 are undefined. The pipeline holds them stable.
- Sub-word stores are not merged here: only full-word writes are supported.

## Timing
- Reset (asynchronous):
  - State = IDLE.
  - All `valid` and `dirty` bits = 0.
  - `mem_read` = `mem_write` = 0, `mem_address` = 0, `mem_writedata` = 0.
  - `readdata` = 0 while no line is valid; `busywait` = 0 with no request.
- Reset mid-miss: the memory transaction is abandoned immediately, requests drop in the same cycle, and the cache ends up fully invalid.
- Hit: latency 0, data valid in the request cycle, no stall.
- Clean miss: 1 IDLE cycle + N ALLOCATE cycles (memory latency) + 1 UPDATE cycle + 1 hit cycle.
- Dirty miss: adds N' WRITE_BACK cycles.
- Memory requests are registered. They are asserted from the cycle after the miss is detected, held stable, and dropped the cycle after `mem_busywait` goes low.
- A store hit updates the array at the rising edge that ends the request cycle. A load to the same word in the following cycle returns the new data.

## Structure
- Shared package `cache_pkg`:
  - state enum `{IDLE, WRITE_BACK, ALLOCATE, UPDATE}`.
  - block width 128 and word-offset width 2.
  - address field slice helpers, reused later by the instruction cache.
- One natural sub-module, `dcache_ctrl_fsm`: the state register, next-state logic and memory-request outputs. The storage arrays and hit logic remain in `data_cache`.

## Test plan
- After reset, read `0x00000010` with memory latency 4 → `busywait` = 1. `mem_read` fires at block address `0x0000001`. Returns the word at offset 0 after 4 + 2 cycles; the next read of `0x14` hits with no stall.
- Write `0xDEADBEEF` to `0x14` on a hit → no stall, `dirty[1]` = 1. Reading `0x14` the next cycle returns `0xDEADBEEF`.
- Read `0x00000094` (same index 1, different tag) → WRITE_BACK with `mem_address` = `0x0000001` and word 1 = `0xDEADBEEF`. Then ALLOCATE at `0x0000009`, then a hit.
- Write miss to a clean set at `0x200` → ALLOCATE only, no `mem_write`. The word is written on the retry and the line ends dirty.
- Assert `RESET` during ALLOCATE → `mem_read` = 0 immediately and state = IDLE. Reading any earlier-cached address misses.
- Back-to-back hits on alternate sets across 16 cycles → `busywait` stays 0 and `mem_read` = `mem_write` = 0 throughout.
